// File: rtl/draw_scheduler_if.sv
// Engine-side bus between the draw scheduler and one pixel engine.
// The scheduler holds the master modport: it issues start and consumes
// done plus the engine's ROM address and pixel-write bus. The engine
// holds the slave modport.
interface draw_scheduler_if #(
    parameter int ADDR_W = 16,
    parameter int RGB_W  = 24
);
    logic              start;
    logic              done;
    logic [ADDR_W-1:0] rom_addr;
    logic              plot;
    logic [7:0]        x;
    logic [6:0]        y;
    logic [RGB_W-1:0]  colour;

    modport master (
        output start,
        input  done,
        input  rom_addr,
        input  plot,
        input  x,
        input  y,
        input  colour
    );

    modport slave (
        input  start,
        output done,
        output rom_addr,
        output plot,
        output x,
        output y,
        output colour
    );
endinterface

// File: rtl/draw_scheduler.sv
// Per-frame sequencer and bus owner for the map and player-tile engines.
// Each frame tick runs the map engine to completion, then the tile engine.
// Only the engine in its phase may reach the shared ROM port and the
// VGA write port. Each run phase has a watchdog; aborted phases leave a
// sticky error bit, and ticks arriving while busy are counted as overruns.
module draw_scheduler #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000,
    parameter int          ADDR_W         = 16,
    parameter int          RGB_W          = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    draw_scheduler_if.master   map,
    draw_scheduler_if.master   tile,
    output logic [ADDR_W-1:0]  rom_address,
    output logic               plot,
    output logic [7:0]         x,
    output logic [6:0]         y,
    output logic [RGB_W-1:0]   colour,
    output logic               busy,
    output logic [7:0]         overrun_count,
    output logic [1:0]         timeout_err
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] MAP_START  = 3'd1;
    localparam logic [2:0] MAP_RUN    = 3'd2;
    localparam logic [2:0] TILE_START = 3'd3;
    localparam logic [2:0] TILE_RUN   = 3'd4;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [19:0] watchdog;
    logic [19:0] watchdog_next;
    logic [1:0]  timeout_err_next;
    logic        watchdog_expired;

    // The last permitted RUN cycle is the one where the watchdog reads TIMEOUT_CYCLES-1.
    assign watchdog_expired = (watchdog == TIMEOUT_CYCLES - 20'd1);

    // Next-state, watchdog and error-flag computation.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
        state_next       = state;
        watchdog_next    = 20'd0;
        timeout_err_next = timeout_err;
        case (state)
            IDLE: begin
                if (frame_tick) state_next = MAP_START;
            end
            MAP_START: begin
                state_next = MAP_RUN;
            end
            MAP_RUN: begin
                if (map.done) begin
                    state_next = TILE_START;
                end else if (watchdog_expired) begin
                    timeout_err_next[0] = 1'b1;
                    state_next          = TILE_START;
                end else begin
                    watchdog_next = watchdog + 20'd1;
                end
            end
            TILE_START: begin
                state_next = TILE_RUN;
            end
            TILE_RUN: begin
                if (tile.done) begin
                    state_next = IDLE;
                end else if (watchdog_expired) begin
                    timeout_err_next[1] = 1'b1;
                    state_next          = IDLE;
                end else begin
                    watchdog_next = watchdog + 20'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, watchdog and sticky error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state       <= IDLE;
            watchdog    <= 20'd0;
            timeout_err <= 2'b00;
        end else begin
            state       <= state_next;
            watchdog    <= watchdog_next;
            timeout_err <= timeout_err_next;
        end
    end

    // Count ticks dropped while busy, saturating at 255.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_count <= 8'd0;
        end else if (frame_tick && (state != IDLE) && (overrun_count != 8'hFF)) begin
            overrun_count <= overrun_count + 8'd1;
        end
    end

    // Start pulses are one cycle long because each START state lasts exactly one cycle.
    assign map.start  = (state == MAP_START);
    assign tile.start = (state == TILE_START);
    assign busy       = (state != IDLE);

    // Grant mux: only the engine owning the current phase reaches the shared ports.
    always_comb begin
        rom_address = '0;
        plot        = 1'b0;
        x           = 8'd0;
        y           = 7'd0;
        colour      = '0;
        case (state)
            MAP_START, MAP_RUN: begin
                rom_address = map.rom_addr;
                plot        = map.plot;
                x           = map.x;
                y           = map.y;
                colour      = map.colour;
            end
            TILE_START, TILE_RUN: begin
                rom_address = tile.rom_addr;
                plot        = tile.plot;
                x           = tile.x;
                y           = tile.y;
                colour      = tile.colour;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: frame sequencing, grant mux,
// overrun saturation, ignored done inputs, watchdog abort and mid-phase reset.
module tb_draw_scheduler;

    logic clk = 1'b0;
    logic reset;
    logic frame_tick;
    logic frame_tick2;

    int vec_cnt = 0;
    int err_cnt = 0;
    int map_pulses = 0;
    int tile_pulses = 0;

    logic [15:0] rom_address, rom_address2;
    logic        plot, plot2;
    logic [7:0]  x, x2;
    logic [6:0]  y, y2;
    logic [23:0] colour, colour2;
    logic        busy, busy2;
    logic [7:0]  overrun_count, overrun_count2;
    logic [1:0]  timeout_err, timeout_err2;

    draw_scheduler_if #(.ADDR_W(16), .RGB_W(24)) m_if ();
    draw_scheduler_if #(.ADDR_W(16), .RGB_W(24)) t_if ();
    draw_scheduler_if #(.ADDR_W(16), .RGB_W(24)) m2_if ();
    draw_scheduler_if #(.ADDR_W(16), .RGB_W(24)) t2_if ();

    draw_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .map           (m_if),
        .tile          (t_if),
        .rom_address   (rom_address),
        .plot          (plot),
        .x             (x),
        .y             (y),
        .colour        (colour),
        .busy          (busy),
        .overrun_count (overrun_count),
        .timeout_err   (timeout_err)
    );

    draw_scheduler #(.TIMEOUT_CYCLES(20'd16)) dut_wd (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick2),
        .map           (m2_if),
        .tile          (t2_if),
        .rom_address   (rom_address2),
        .plot          (plot2),
        .x             (x2),
        .y             (y2),
        .colour        (colour2),
        .busy          (busy2),
        .overrun_count (overrun_count2),
        .timeout_err   (timeout_err2)
    );

    always #5 clk = ~clk;

    // Count start pulses mid-cycle on the main DUT.
    always @(negedge clk) begin
        if (m_if.start === 1'b1) map_pulses++;
        if (t_if.start === 1'b1) tile_pulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL time_limit: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        reset = 1'b1;
        frame_tick = 1'b0;
        frame_tick2 = 1'b0;
        m_if.done = 1'b0; m_if.rom_addr = 16'h0ABC; m_if.plot = 1'b1;
        m_if.x = 8'd40; m_if.y = 7'd5; m_if.colour = 24'h123456;
        t_if.done = 1'b0; t_if.rom_addr = 16'h1234; t_if.plot = 1'b1;
        t_if.x = 8'd99; t_if.y = 7'd17; t_if.colour = 24'h654321;
        m2_if.done = 1'b0; m2_if.rom_addr = 16'h0; m2_if.plot = 1'b0;
        m2_if.x = 8'd0; m2_if.y = 7'd0; m2_if.colour = 24'h0;
        t2_if.done = 1'b0; t2_if.rom_addr = 16'h0; t2_if.plot = 1'b0;
        t2_if.x = 8'd0; t2_if.y = 7'd0; t2_if.colour = 24'h0;

        // Reset state: IDLE, engine buses blocked even though both drive plot=1.
        step(); step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_map_start", m_if.start, 1'b0);
        chk("rst_tile_start", t_if.start, 1'b0);
        chk("rst_plot", plot, 1'b0);
        chk("rst_x", x, 8'd0);
        chk("rst_rom", rom_address, 16'd0);
        chk("rst_colour", colour, 24'd0);
        chk("rst_overrun", overrun_count, 8'd0);
        chk("rst_err", timeout_err, 2'b00);
        reset = 1'b0;

        // Idle until cycle 10; no start without a tick.
        repeat (9) step();
        chk("idle_no_start", m_if.start, 1'b0);

        // Tick -> map_start on the very next cycle with the map engine granted.
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("map_start_pulse", m_if.start, 1'b1);
        chk("map_busy", busy, 1'b1);
        chk("map_grant_rom", rom_address, 16'h0ABC);
        step();
        chk("map_start_one_cycle", m_if.start, 1'b0);
        chk("map_run_plot", plot, 1'b1);
        chk("map_run_x", x, 8'd40);
        chk("map_run_y", y, 7'd5);
        chk("map_run_colour", colour, 24'h123456);

        // tile_done during MAP_RUN is ignored.
        t_if.done = 1'b1; step(); t_if.done = 1'b0;
        chk("tile_done_ignored_start", t_if.start, 1'b0);
        chk("tile_done_ignored_x", x, 8'd40);

        // Three ticks while busy -> three overruns, no extra map_start.
        for (int i = 0; i < 3; i++) begin
            frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
        end
        chk("overrun_3", overrun_count, 8'd3);
        chk("map_pulses_1", map_pulses, 1);

        // Map completes -> tile phase with tile engine granted.
        repeat (20) step();
        m_if.done = 1'b1; step(); m_if.done = 1'b0;
        chk("tile_start_pulse", t_if.start, 1'b1);
        chk("tile_grant_x", x, 8'd99);
        chk("tile_grant_y", y, 7'd17);
        step();
        chk("tile_start_one_cycle", t_if.start, 1'b0);
        chk("tile_run_x", x, 8'd99);
        chk("tile_run_rom", rom_address, 16'h1234);

        // map_done during TILE_RUN is ignored.
        m_if.done = 1'b1; step(); m_if.done = 1'b0;
        chk("map_done_ignored_busy", busy, 1'b1);
        chk("map_done_ignored_x", x, 8'd99);

        // tile_done together with a tick: frame ends, tick counted as overrun.
        t_if.done = 1'b1; frame_tick = 1'b1; step();
        t_if.done = 1'b0; frame_tick = 1'b0;
        chk("frame_done_busy", busy, 1'b0);
        chk("frame_done_overrun", overrun_count, 8'd4);
        chk("idle_plot", plot, 1'b0);
        chk("idle_x", x, 8'd0);
        chk("frame_err", timeout_err, 2'b00);
        step(); step();
        chk("tick_not_queued", busy, 1'b0);
        chk("map_pulses_frame", map_pulses, 1);
        chk("tile_pulses_frame", tile_pulses, 1);

        // Saturation: start a frame, then hold the tick for 300 busy cycles.
        frame_tick = 1'b1; step();
        repeat (300) step();
        frame_tick = 1'b0;
        chk("overrun_sat", overrun_count, 8'd255);
        chk("map_pulses_sat", map_pulses, 2);

        // Move into TILE_RUN, then reset asynchronously mid-phase.
        m_if.done = 1'b1; step(); m_if.done = 1'b0;
        step();
        chk("pre_reset_busy", busy, 1'b1);
        reset = 1'b1; #2;
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_x", x, 8'd0);
        chk("async_rst_plot", plot, 1'b0);
        chk("async_rst_tile_start", t_if.start, 1'b0);
        chk("async_rst_overrun", overrun_count, 8'd0);
        reset = 1'b0;
        step();
        chk("post_rst_no_map_start", m_if.start, 1'b0);
        chk("post_rst_tile_pulses", tile_pulses, 2);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("restart_map_start", m_if.start, 1'b1);
        step();
        chk("restart_map_pulses", map_pulses, 3);

        // Watchdog instance (TIMEOUT_CYCLES=16): map_done never arrives.
        frame_tick2 = 1'b1; step(); frame_tick2 = 1'b0;
        chk("wd_map_start", m2_if.start, 1'b1);
        step();
        repeat (15) step();
        chk("wd_run16_err", timeout_err2, 2'b00);
        chk("wd_run16_no_tile", t2_if.start, 1'b0);
        step();
        chk("wd_abort_tile_start", t2_if.start, 1'b1);
        chk("wd_abort_err", timeout_err2, 2'b01);
        step();
        t2_if.done = 1'b1; step(); t2_if.done = 1'b0;
        chk("wd_tile_done_idle", busy2, 1'b0);
        chk("wd_err_sticky", timeout_err2, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Per-frame sequencer and bus owner for the two pixel engines (map_drawer, tile_drawer). These engines share the single rom24 port and the single vga_adapter write port.
- On each frame tick it starts the map engine, waits for its done, then starts the player-tile engine and waits for its done.
- Only the engine that currently holds the grant may drive rom_address, plot, x, y and colour.
- Watchdog per phase, overrun counting and error flags.

Parameters:
- TIMEOUT_CYCLES, 20'd100000, maximum clk cycles a phase may stay in RUN before it is aborted (map redraw is 19200 pixels).
- ADDR_W, 16, ROM address width.
- RGB_W, 24, colour width.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse at 60 Hz from the frame divider.
- map_start  out  1  one-cycle start pulse to map_drawer.
- map_done  in  1  map_drawer completion (pulse or level, >=1 cycle).
- map_rom_addr  in  ADDR_W  map_drawer ROM address.
- map_plot  in  1  map_drawer write enable.
- map_x  in  8, map_y  in  7, map_colour  in  RGB_W  map_drawer pixel bus.
- tile_start  out  1  one-cycle start pulse to tile_drawer.
- tile_done  in  1  tile_drawer completion.
- tile_rom_addr  in  ADDR_W  tile_drawer ROM address.
- tile_plot  in  1  tile_drawer write enable.
- tile_x  in  8, tile_y  in  7, tile_colour  in  RGB_W  tile_drawer pixel bus.
- rom_address  out  ADDR_W  to rom24.
- plot  out  1, x  out  8, y  out  7, colour  out  RGB_W  to vga_adapter.
- busy  out  1  high in every state except IDLE.
- overrun_count  out  8  frame ticks dropped because the scheduler was busy.
- timeout_err  out  2  sticky; bit0 = map phase aborted, bit1 = tile phase aborted.

Behaviour:
- States: IDLE, MAP_START, MAP_RUN, TILE_START, TILE_RUN. State is registered.
- Reset (asynchronous) forces:
  - state = IDLE
  - map_start = tile_start = 0
  - overrun_count = 0, timeout_err = 0
  - watchdog = 0
  - all bus outputs = 0
- IDLE: frame_tick sampled high -> MAP_START on the next edge. Outputs map_start=1 exactly one cycle, so the latency is 1 cycle from the tick.
- MAP_START -> MAP_RUN unconditionally. The watchdog clears to 0.
- MAP_RUN:
  - map_done high -> TILE_START.
  - Otherwise, when the watchdog reaches TIMEOUT_CYCLES-1, set timeout_err[0] and go to TILE_START.
  - Otherwise the watchdog increments.
- TILE_START: tile_start=1 for one cycle -> TILE_RUN. The watchdog clears.
- TILE_RUN:
  - tile_done high -> IDLE.
  - Watchdog expiry sets timeout_err[1] and goes to IDLE.
- A done input is sampled only in its own RUN state. A done seen in START, IDLE or the other phase is ignored.
- Grant mux (combinational from registered state):
  - MAP_START/MAP_RUN select map_* signals.
  - TILE_START/TILE_RUN select tile_* signals.
  - IDLE drives rom_address=0, plot=0, x=0, y=0, colour=0.
  - plot of the non-granted engine never reaches the output.
- frame_tick while busy=1:
  - The tick is dropped and no restart occurs.
  - overrun_count increments and saturates at 255; it does not wrap.
- frame_tick in the same cycle as the tile_done that returns the scheduler to IDLE counts as an overrun. It is not queued.
- timeout_err and overrun_count clear only on reset.
- Reset mid-phase returns to IDLE immediately, with no start pulse re-issued. The engines are expected to be reset by the same signal.

Test Plan:
- Reset, then frame_tick at cycle 10; map_done at cycle 50; tile_done at cycle 120.
  - map_start high only at cycle 11 and tile_start high only at cycle 51.
  - busy falls after cycle 120.
  - overrun_count=0, timeout_err=0.
- During MAP_RUN, drive map_plot=1, map_x=8'd40, tile_plot=1, tile_x=8'd99.
  - Outputs plot=1, x=40.
  - In TILE_RUN, x=99.
  - In IDLE, plot=0 and x=0.
- Issue 3 frame_ticks during MAP_RUN -> overrun_count=3, no extra map_start. Then issue 300 ticks while busy -> count holds at 255.
- With TIMEOUT_CYCLES=16, never assert map_done.
  - timeout_err=2'b01 after 16 RUN cycles and tile_start pulses.
  - tile_done completes the frame normally.
- Assert tile_done during MAP_RUN -> ignored; map phase continues until map_done.
- Assert reset mid TILE_RUN -> all outputs 0, state IDLE. The next frame_tick restarts at map_start with 1-cycle latency.
